// File: rtl/game_pkg.sv
// Shared game constants and the pellet tracker state type.
// Raster offsets are common to the movement, ghost and pellet stages.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [9:0] OFFSETH   = 10'd274;
   localparam logic [9:0] OFFSETV   = 10'd58;
   localparam logic [9:0] CELL      = 10'd20;

   localparam int         COLS      = 19;
   localparam int         ROWS      = 21;
   localparam int         NCELLS    = ROWS * COLS;
   localparam int         IDX_W     = $clog2(NCELLS);

   localparam logic [9:0] FIELD_W   = 10'(COLS) * CELL;
   localparam logic [9:0] FIELD_H   = 10'(ROWS) * CELL;

   localparam logic [4:0] PEL_LO    = 5'd8;
   localparam logic [4:0] PEL_SIZE  = 5'd4;
   localparam logic [4:0] PEL_HI    = PEL_LO + PEL_SIZE - 5'd1;

   localparam logic [15:0] WIN_SCORE = 16'd30;
   localparam logic [15:0] SCORE_MAX = 16'hFFFF;

   // Flat pellet index, row-major.
   function automatic logic [IDX_W-1:0] cell_index(input logic [4:0] row,
                                                   input logic [4:0] col);
      return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
   endfunction

endpackage

// File: rtl/pellet_cell_locator.sv
// Maps the raster position to a pellet grid cell and flags pixels inside
// the pellet square of that cell. All constant-divide logic lives here.
module pellet_cell_locator
   import game_pkg::*;
(
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   output logic [4:0] col,
   output logic [4:0] row,
   output logic       onPellet
);

   logic [9:0] x;
   logic [9:0] y;
   logic [4:0] px;
   logic [4:0] py;
   logic       in_field;

   always_comb begin
      x = hCount - OFFSETH;
      y = vCount - OFFSETV;
      // Explicit lower bounds so a raster left of / above the field never wraps in.
      in_field = (hCount >= OFFSETH) && (vCount >= OFFSETV) &&
                 (x < FIELD_W) && (y < FIELD_H);
      col = 5'(x / CELL);
      row = 5'(y / CELL);
      px  = 5'(x % CELL);
      py  = 5'(y % CELL);
      onPellet = in_field &&
                 (px >= PEL_LO) && (px <= PEL_HI) &&
                 (py >= PEL_LO) && (py <= PEL_HI);
   end

endmodule

// File: rtl/pellet_tracker.sv
// Pellet field owner: draws uneaten pellets, scores overlaps with Pac-Man
// and raises win once the target count is eaten.
//
//   state | meaning
//   IDLE  | waiting for start; field drawn, overlaps ignored
//   PLAY  | overlaps eat pellets and count into score
//   DONE  | game over (win or lose); field and score frozen until ack
module pellet_tracker
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ack,
   input  logic        lose,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic        pacmanFill,
   output logic        pelletFill,
   output logic [15:0] score,
   output logic        win
);

   state_t            state;
   state_t            state_next;
   logic [4:0]        col;
   logic [4:0]        row;
   logic              on_pellet;
   logic [IDX_W-1:0]  idx;
   logic [NCELLS-1:0] eaten;
   logic [15:0]       score_inc;
   logic              eat;
   logic              clear_field;
   logic              win_set;
   logic              won;

   pellet_cell_locator u_locator (
      .hCount   (hCount),
      .vCount   (vCount),
      .col      (col),
      .row      (row),
      .onPellet (on_pellet)
   );

   assign idx        = cell_index(row, col);
   // on_pellet is only true inside the grid, so idx is always in range when it matters.
   assign pelletFill = on_pellet && !eaten[idx];
   assign score_inc  = (score == SCORE_MAX) ? score : score + 16'd1;
   assign win        = won;

   always_comb begin
      state_next  = state;
      eat         = 1'b0;
      clear_field = 1'b0;
      win_set     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = PLAY;
         end
         PLAY: begin
            eat = pelletFill && pacmanFill;
            // lose wins over a simultaneous winning eat; the eat still counts.
            if (lose) begin
               state_next = DONE;
            end else if (eat && (score_inc == WIN_SCORE)) begin
               state_next = DONE;
               win_set    = 1'b1;
            end
         end
         DONE: begin
            if (ack) begin
               state_next  = IDLE;
               clear_field = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         eaten <= '0;
         score <= '0;
         won   <= 1'b0;
      end else if (clear_field) begin
         eaten <= '0;
         score <= '0;
         won   <= 1'b0;
      end else begin
         if (eat) begin
            eaten[idx] <= 1'b1;
            score      <= score_inc;
         end
         if (win_set) won <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker: reset, idle overlap, eating, winning,
// lose priority and mid-game reset, with hand-computed expectations.
module tb_pellet_tracker;

   logic        clk;
   logic        reset;
   logic        start;
   logic        ack;
   logic        lose;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        pacmanFill;
   logic        pelletFill;
   logic [15:0] score;
   logic        win;

   int tests;
   int fails;

   pellet_tracker dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ack        (ack),
      .lose       (lose),
      .hCount     (hCount),
      .vCount     (vCount),
      .pacmanFill (pacmanFill),
      .pelletFill (pelletFill),
      .score      (score),
      .win        (win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pixel (dx,dy) inside cell (col,row); dx=dy=8 is the pellet's first pixel.
   task automatic set_pix(input int c, input int r, input int dx, input int dy);
      hCount = 10'(274 + c * 20 + dx);
      vCount = 10'(58 + r * 20 + dy);
      #1;
   endtask

   task automatic eat_cell(input int k);
      set_pix(k % 19, k / 19, 8, 8);
      pacmanFill = 1'b1;
      tick();
      pacmanFill = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      hCount = 10'd282; vCount = 10'd66; #1;
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL reset_pellet got %b want 1", pelletFill); end
      tests++; if (score !== 16'd0) begin fails++; $display("FAIL reset_score got %0d want 0", score); end
      tests++; if (win !== 1'b0) begin fails++; $display("FAIL reset_win got %b want 0", win); end
      hCount = 10'd281; #1;
      tests++; if (pelletFill !== 1'b0) begin fails++; $display("FAIL left_of_pellet got %b want 0", pelletFill); end
      hCount = 10'd285; #1;
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL pellet_last_px got %b want 1", pelletFill); end
      hCount = 10'd286; #1;
      tests++; if (pelletFill !== 1'b0) begin fails++; $display("FAIL right_of_pellet got %b want 0", pelletFill); end
      hCount = 10'd273; vCount = 10'd66; #1;
      tests++; if (pelletFill !== 1'b0) begin fails++; $display("FAIL left_of_field got %b want 0", pelletFill); end
      set_pix(18, 20, 11, 11);
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL last_cell got %b want 1", pelletFill); end
      set_pix(19, 20, 8, 8);
      tests++; if (pelletFill !== 1'b0) begin fails++; $display("FAIL beyond_cols got %b want 0", pelletFill); end
      set_pix(0, 21, 8, 8);
      tests++; if (pelletFill !== 1'b0) begin fails++; $display("FAIL beyond_rows got %b want 0", pelletFill); end
   endtask

   task automatic test_idle_overlap();
      pacmanFill = 1'b1;
      for (int dy = 8; dy < 12; dy++)
         for (int dx = 8; dx < 12; dx++) begin
            set_pix(2, 3, dx, dy);
            tick();
         end
      pacmanFill = 1'b0;
      set_pix(2, 3, 8, 8);
      tests++; if (score !== 16'd0) begin fails++; $display("FAIL idle_score got %0d want 0", score); end
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL idle_pellet got %b want 1", pelletFill); end
   endtask

   task automatic test_first_eat();
      pulse_start();
      pacmanFill = 1'b1;
      for (int dy = 8; dy < 12; dy++)
         for (int dx = 8; dx < 12; dx++) begin
            set_pix(0, 0, dx, dy);
            tick();
         end
      pacmanFill = 1'b0;
      tests++; if (score !== 16'd1) begin fails++; $display("FAIL first_eat_score got %0d want 1", score); end
      hCount = 10'd282; vCount = 10'd66; #1;
      tests++; if (pelletFill !== 1'b0) begin fails++; $display("FAIL eaten_pellet got %b want 0", pelletFill); end
      pulse_start();
      tests++; if (score !== 16'd1) begin fails++; $display("FAIL start_in_play got %0d want 1", score); end
   endtask

   task automatic test_win();
      do_reset();
      pulse_start();
      for (int k = 0; k < 29; k++) eat_cell(k);
      tests++; if (score !== 16'd29) begin fails++; $display("FAIL score_29 got %0d want 29", score); end
      tests++; if (win !== 1'b0) begin fails++; $display("FAIL win_early got %b want 0", win); end
      set_pix(29 % 19, 29 / 19, 8, 8);
      pacmanFill = 1'b1; #1;
      tests++; if (win !== 1'b0) begin fails++; $display("FAIL win_before_edge got %b want 0", win); end
      tick();
      pacmanFill = 1'b0;
      tests++; if (score !== 16'd30) begin fails++; $display("FAIL score_30 got %0d want 30", score); end
      tests++; if (win !== 1'b1) begin fails++; $display("FAIL win_set got %b want 1", win); end
      eat_cell(30);
      tests++; if (score !== 16'd30) begin fails++; $display("FAIL done_frozen got %0d want 30", score); end
      set_pix(30 % 19, 30 / 19, 8, 8);
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL done_no_eat got %b want 1", pelletFill); end
      set_pix(5, 0, 8, 8);
      tests++; if (pelletFill !== 1'b0) begin fails++; $display("FAIL done_drawn got %b want 0", pelletFill); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tests++; if (score !== 16'd0) begin fails++; $display("FAIL ack_score got %0d want 0", score); end
      tests++; if (win !== 1'b0) begin fails++; $display("FAIL ack_win got %b want 0", win); end
      set_pix(0, 0, 8, 8);
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL redraw_first got %b want 1", pelletFill); end
      set_pix(29 % 19, 29 / 19, 10, 9);
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL redraw_last got %b want 1", pelletFill); end
      eat_cell(40);
      tests++; if (score !== 16'd0) begin fails++; $display("FAIL idle_after_ack got %0d want 0", score); end
   endtask

   task automatic test_lose_priority();
      pulse_start();
      for (int k = 100; k < 104; k++) eat_cell(k);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tests++; if (score !== 16'd4) begin fails++; $display("FAIL ack_in_play got %0d want 4", score); end
      lose = 1'b1;
      eat_cell(104);
      lose = 1'b0;
      tests++; if (score !== 16'd5) begin fails++; $display("FAIL lose_eat_score got %0d want 5", score); end
      tests++; if (win !== 1'b0) begin fails++; $display("FAIL lose_win got %b want 0", win); end
      eat_cell(105);
      tests++; if (score !== 16'd5) begin fails++; $display("FAIL lose_done got %0d want 5", score); end
   endtask

   task automatic test_reset_mid_game();
      do_reset();
      pulse_start();
      for (int k = 0; k < 5; k++) eat_cell(k);
      tests++; if (score !== 16'd5) begin fails++; $display("FAIL pre_reset_score got %0d want 5", score); end
      do_reset();
      tests++; if (score !== 16'd0) begin fails++; $display("FAIL midreset_score got %0d want 0", score); end
      set_pix(0, 0, 8, 8);
      tests++; if (pelletFill !== 1'b1) begin fails++; $display("FAIL midreset_pellet got %b want 1", pelletFill); end
      eat_cell(0);
      tests++; if (score !== 16'd0) begin fails++; $display("FAIL midreset_idle got %0d want 0", score); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      start = 1'b0;
      ack = 1'b0;
      lose = 1'b0;
      hCount = '0;
      vCount = '0;
      pacmanFill = 1'b0;
      tick();
      test_reset();
      test_idle_overlap();
      test_first_eat();
      test_win();
      test_lose_priority();
      test_reset_mid_game();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
